riscv_core_top: RTL and testbench
=================================

Name: riscv_core_top

Overview:
Minimal single-cycle RV32I-subset core wrapped in the standard 8-bit tile pin interface. It executes a fixed program from an internal 16-word instruction ROM, one instruction per clock. Stores drive the 8-bit output port, and loads read the 8-bit input port. It is the top level of the tile; the bench checks the output port only.

Parameters:
ROM_WORDS, 16, instruction ROM depth in 32-bit words; the ROM is indexed by PC[5:2].
NREGS, 16, number of 32-bit GPRs (x0..x15, RV32E-sized); x0 is hardwired to 0.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
ui_in  input  8  input port, read by LW.
uo_out  output  8  output port register, written by SW.
uio_in  input  8  unused; no effect on behaviour.
uio_out  output  8  PC[9:2] debug byte.
uio_oe  output  8  constant 8'hFF.

Behaviour:
- Reset (async, rst=1): PC=0, all GPRs=0, uo_out=0. uio_out therefore reads 0. Reset is honoured mid-program; the core restarts at PC 0 on the first edge after release.
- Execution: each rising edge with rst=0 executes ROM[PC[5:2]] completely.
  - Register write and PC update happen on that edge.
  - There is no pipeline, no stall and no handshake.
- Supported instructions, with standard RV32I encodings and semantics:
  - ADDI, ADD, SUB, AND, OR, XOR: 32-bit, wrap-around arithmetic.
  - LW: rd <= {24'b0, ui_in}. The address is ignored.
  - SW: uo_out <= rs2[7:0]. The address is ignored.
  - BEQ, BNE: target = PC + sign-extended B-immediate.
  - JAL: rd <= PC+4; PC <= PC + sign-extended J-immediate.
- Register index rules:
  - Writes to x0 are discarded; x0 always reads 0.
  - Register indices use bits [3:0] only.
- Any other opcode or funct combination executes as a NOP: PC+4, no state change.
- PC is 32 bits and wraps naturally. A fetch beyond ROM_WORDS aliases through PC[5:2].
- ROM contents (word address: hex, meaning):
  - 0: 0x00000093, addi x1,x0,0
  - 1: 0x00100113, addi x2,x0,1
  - 2: 0x002080B3, add x1,x1,x2
  - 3: 0x00102023, sw x1,0(x0)
  - 4: 0xFF9FF06F, jal x0,-8 (to PC 8)
  - 5-15: 0x00000013, nop
- Resulting timing (edge n = nth rising edge after reset release, n from 1):
  - The SW executes at edges n = 4, 7, 10, ...
  - After the SW at edge n, uo_out = ((n-1)/3) mod 256.
  - Steady-state loop period is 3 cycles; the counter wraps 255 to 0.
- uio_out is combinational from the PC register.

Test Plan:
1. Hold rst=1 for 10 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF throughout.
2. Release rst, run 4 edges -> after edges 1-3 uo_out=0x00; after edge 4 uo_out=0x01. uio_out sequence after edges 1-5: 0x01, 0x02, 0x03, 0x04, 0x02.
3. Run 500 edges after release -> the last SW is at edge 499, so uo_out=166 (0xA6).
4. Run 772 edges (257 SWs) -> uo_out wraps to 0x01; confirms 8-bit truncation of x1.
5. Assert rst asynchronously (between edges) at edge 50 while uo_out=0x10 -> uo_out and uio_out go to 0x00 immediately, without waiting for a clock edge. After release, the edge-2 sequence repeats exactly.
6. Toggle ui_in and uio_in randomly during a run -> uo_out sequence identical to scenario 3 (the program contains no LW).

Source files
------------

// File: rtl/riscv_core_top.sv
// Single-cycle RV32I-subset core on the 8-bit tile pin interface.
// Runs a fixed 16-word ROM program; SW drives uo_out, LW reads ui_in.
module riscv_core_top #(
  parameter int ROM_WORDS = 16,
  parameter int NREGS     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int AW = $clog2(ROM_WORDS);
  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] pc;
  logic [31:0] regs [NREGS];
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [RW-1:0] rd, rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_b, imm_j;
  logic [31:0] next_pc;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        st_en;
  logic        unused_in;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] addr);
    logic [31:0] w;
    case (addr)
      AW'(0):  w = 32'h0000_0093;
      AW'(1):  w = 32'h0010_0113;
      AW'(2):  w = 32'h0020_80B3;
      AW'(3):  w = 32'h0010_2023;
      AW'(4):  w = 32'hFF9F_F06F;
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  assign instr   = rom_word(pc[AW+1:2]);
  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign rd      = instr[7+RW-1:7];
  assign rs1     = instr[15+RW-1:15];
  assign rs2     = instr[20+RW-1:20];
  assign rs1_val = (rs1 == RW'(0)) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == RW'(0)) ? 32'd0 : regs[rs2];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign uio_out   = pc[9:2];
  assign uio_oe    = 8'hFF;
  assign unused_in = ^uio_in;

  // Decode and execute; unrecognised encodings fall through as NOP
  always_comb begin
    next_pc = pc + 32'd4;
    wr_en   = 1'b0;
    wr_data = 32'd0;
    st_en   = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          wr_en   = 1'b1;
          wr_data = rs1_val + imm_i;
        end else begin
          wr_en = 1'b0;
        end
      end
      OP_REG: begin
        case ({funct7, funct3})
          10'b0000000_000: begin wr_en = 1'b1; wr_data = rs1_val + rs2_val; end
          10'b0100000_000: begin wr_en = 1'b1; wr_data = rs1_val - rs2_val; end
          10'b0000000_111: begin wr_en = 1'b1; wr_data = rs1_val & rs2_val; end
          10'b0000000_110: begin wr_en = 1'b1; wr_data = rs1_val | rs2_val; end
          10'b0000000_100: begin wr_en = 1'b1; wr_data = rs1_val ^ rs2_val; end
          default:         wr_en = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          wr_en   = 1'b1;
          wr_data = {24'd0, ui_in};
        end else begin
          wr_en = 1'b0;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          st_en = 1'b1;
        end else begin
          st_en = 1'b0;
        end
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  next_pc = (rs1_val == rs2_val) ? pc + imm_b : pc + 32'd4;
          3'b001:  next_pc = (rs1_val != rs2_val) ? pc + imm_b : pc + 32'd4;
          default: next_pc = pc + 32'd4;
        endcase
      end
      OP_JAL: begin
        wr_en   = 1'b1;
        wr_data = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      default: next_pc = pc + 32'd4;
    endcase
  end

  // Architectural state: PC, register file and output port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= 32'd0;
      uo_out <= 8'd0;
      regs   <= '{default: 32'd0};
    end else begin
      pc <= next_pc;
      if (wr_en && (rd != RW'(0))) begin
        regs[rd] <= wr_data;
      end
      if (st_en) begin
        uo_out <= rs2_val[7:0];
      end
    end
  end
endmodule

// File: tb/tb_riscv_core_top.sv
// Randomized bench for riscv_core_top: compares the pin outputs each cycle
// against a program-level model of the counter loop in the fixed ROM.
module tb_riscv_core_top;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  riscv_core_top dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Counter program: SW every 3 edges starting at edge 4, storing (n-1)/3.
  function automatic logic [7:0] model_uo(input int edges);
    if (edges < 4) return 8'd0;
    return 8'(((edges - 1) / 3) % 256);
  endfunction

  // PC walks 0,4,8,12,16 then loops 8,12,16 via the JAL.
  function automatic logic [7:0] model_dbg(input int edges);
    int pcv;
    if (edges <= 4) pcv = 4 * edges;
    else pcv = 8 + 4 * ((edges - 5) % 3);
    return 8'(pcv >> 2);
  endfunction

  task automatic run(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
      #1;
      n++;
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      check("uo_out", {24'd0, uo_out}, {24'd0, model_uo(n)});
      check("uio_out", {24'd0, uio_out}, {24'd0, model_dbg(n)});
      check("uio_oe", {24'd0, uio_oe}, 32'h0000_00FF);
    end
  endtask

  task automatic hold_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      n = 0;
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      check("rst_uo_out", {24'd0, uo_out}, 32'd0);
      check("rst_uio_out", {24'd0, uio_out}, 32'd0);
      check("rst_uio_oe", {24'd0, uio_oe}, 32'h0000_00FF);
    end
  endtask

  // Raise reset between edges and confirm outputs clear before any edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    check("async_uo_out", {24'd0, uo_out}, 32'd0);
    check("async_uio_out", {24'd0, uio_out}, 32'd0);
    hold_reset(3);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hold_reset(10);
    rst = 1'b0;

    run(4);
    check("first_store", {24'd0, uo_out}, 32'h0000_0001);
    run(496);
    check("edge500", {24'd0, uo_out}, 32'h0000_00A6);
    run(272);
    check("wrap772", {24'd0, uo_out}, 32'h0000_0001);

    async_reset();
    run(50);
    check("edge50", {24'd0, uo_out}, 32'h0000_0010);
    async_reset();
    run(60);

    for (int k = 0; k < 6; k++) begin
      run(int'($urandom_range(1, 300)));
      async_reset();
    end
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
